gfx_frame_ctrl: RTL and testbench

Wishbone-slave control block that configures the gfxdemo video pipeline.
- Holds double-buffered mode/scroll/colour registers written by the CPU and commits them atomically at the frame boundary, so the image never tears.
- Counts frames and raises a vblank interrupt.
- Sits between the wrapper's Wishbone bus and the timing generator/pixel datapath inside myip1.

---
 rtl/gfx_frame_ctrl_pkg.sv | 34 +++
 rtl/gfx_wb_regslave.sv | 63 ++++++
 rtl/gfx_frame_ctrl.sv | 116 +++++++++++
 tb/tb_gfx_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_frame_ctrl_pkg.sv
// Shared register map, bit positions and commit-state encoding for the
// gfxdemo frame controller.
package gfx_frame_ctrl_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_SCROLL    = 8'h04;
  localparam logic [7:0] REG_COLOR     = 8'h08;
  localparam logic [7:0] REG_STATUS    = 8'h0C;
  localparam logic [7:0] REG_FRAME_CNT = 8'h10;
  localparam logic [7:0] REG_COMMIT    = 8'h14;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IRQ_EN   = 8;
  localparam int STATUS_IRQ    = 0;
  localparam int STATUS_UPD    = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

  // Replace only the byte lanes enabled by sel.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  lane_sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (lane_sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/gfx_wb_regslave.sv
// Wishbone slave front end: 256-byte window decode, single-cycle ack, registered
// read mux; hands accepted writes to the owner as a one-cycle strobe.
module gfx_wb_regslave
  import gfx_frame_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] dat_w,
  input  logic [3:0]  sel,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  output logic        ack,
  output logic [31:0] dat_r,
  output logic        wr,
  output logic [7:0]  off,
  output logic [31:0] wdat,
  output logic [3:0]  wsel,
  input  logic [31:0] ctrl_val,
  input  logic [31:0] scroll_val,
  input  logic [31:0] color_val,
  input  logic [31:0] status_val,
  input  logic [31:0] cnt_val
);

  logic        hit;
  logic        accept;
  logic [31:0] rd_mux;

  assign hit    = (adr[31:8] == BASE_ADDR[31:8]);
  // Gating on !ack keeps a held strobe from being acked twice in a row.
  assign accept = cyc & stb & hit & ~ack;
  assign wr     = accept & we;
  assign off    = adr[7:0];
  assign wdat   = dat_w;
  assign wsel   = sel;

  always_comb begin
    rd_mux = 32'h0;
    case (adr[7:0])
      REG_CTRL:      rd_mux = ctrl_val;
      REG_SCROLL:    rd_mux = scroll_val;
      REG_COLOR:     rd_mux = color_val;
      REG_STATUS:    rd_mux = status_val;
      REG_FRAME_CNT: rd_mux = cnt_val;
      default:       rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      dat_r <= 32'h0;
    end else begin
      ack   <= accept;
      dat_r <= (accept & ~we) ? rd_mux : 32'h0;
    end
  end

endmodule

// File: rtl/gfx_frame_ctrl.sv
// Frame controller: CPU-written shadow registers committed to the video
// pipeline at frame_start, frame counter and vblank interrupt.
module gfx_frame_ctrl
  import gfx_frame_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SCROLL_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         wb__adr,
  input  logic [31:0]         wb__dat_w,
  output logic [31:0]         wb__dat_r,
  input  logic [3:0]          sel,
  input  logic                wb__cyc,
  input  logic                wb__stb,
  input  logic                wb__we,
  output logic                wb__ack,
  input  logic                frame_start,
  output logic                enable,
  output logic [1:0]          mode,
  output logic [SCROLL_W-1:0] scroll_x,
  output logic [SCROLL_W-1:0] scroll_y,
  output logic [23:0]         color,
  output logic                irq
);

  localparam logic [31:0] SCROLL_FIELD = (32'd1 << SCROLL_W) - 32'd1;
  localparam logic [31:0] SCROLL_MASK  = SCROLL_FIELD | (SCROLL_FIELD << 16);
  localparam logic [31:0] CTRL_MASK    = 32'h0000_0107;
  localparam logic [31:0] COLOR_MASK   = 32'h00FF_FFFF;

  logic          wr;
  logic [7:0]    off;
  logic [31:0]   wdat;
  logic [3:0]    wsel;
  logic [31:0]   sh_ctrl, sh_scroll, sh_color;
  logic          irq_pending;
  logic [15:0]   frame_cnt;
  commit_state_t state;
  logic          commit_wr, w1c_irq;
  logic [31:0]   status_val;

  gfx_wb_regslave #(.BASE_ADDR(BASE_ADDR)) u_regslave (
    .clk        (clk),
    .rst        (reset),
    .adr        (wb__adr),
    .dat_w      (wb__dat_w),
    .sel        (sel),
    .cyc        (wb__cyc),
    .stb        (wb__stb),
    .we         (wb__we),
    .ack        (wb__ack),
    .dat_r      (wb__dat_r),
    .wr         (wr),
    .off        (off),
    .wdat       (wdat),
    .wsel       (wsel),
    .ctrl_val   (sh_ctrl),
    .scroll_val (sh_scroll),
    .color_val  (sh_color),
    .status_val (status_val),
    .cnt_val    ({16'h0, frame_cnt})
  );

  assign commit_wr  = wr && (off == REG_COMMIT);
  assign w1c_irq    = wr && (off == REG_STATUS) && wsel[0] && wdat[STATUS_IRQ];
  assign status_val = {30'h0, state == ST_PENDING, irq_pending};
  assign irq        = irq_pending & sh_ctrl[CTRL_IRQ_EN];

  // Shadows hold full 32-bit images with unimplemented bits forced to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_ctrl     <= 32'h0;
      sh_scroll   <= 32'h0;
      sh_color    <= 32'h0;
      irq_pending <= 1'b0;
      frame_cnt   <= 16'h0;
    end else begin
      if (wr && off == REG_CTRL)   sh_ctrl   <= byte_merge(sh_ctrl, wdat, wsel) & CTRL_MASK;
      if (wr && off == REG_SCROLL) sh_scroll <= byte_merge(sh_scroll, wdat, wsel) & SCROLL_MASK;
      if (wr && off == REG_COLOR)  sh_color  <= byte_merge(sh_color, wdat, wsel) & COLOR_MASK;
      if (frame_start)             irq_pending <= 1'b1;
      else if (w1c_irq)            irq_pending <= 1'b0;
      frame_cnt <= frame_cnt + {15'h0, frame_start};
    end
  end

  // Active outputs load from the pre-edge shadows, so a same-edge write misses this frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      enable   <= 1'b0;
      mode     <= 2'b00;
      scroll_x <= '0;
      scroll_y <= '0;
      color    <= 24'h0;
    end else begin
      case (state)
        ST_IDLE: if (commit_wr) state <= ST_PENDING;
        ST_PENDING: begin
          if (frame_start) begin
            enable   <= sh_ctrl[CTRL_ENABLE];
            mode     <= sh_ctrl[CTRL_MODE_LSB +: 2];
            scroll_x <= sh_scroll[SCROLL_W-1:0];
            scroll_y <= sh_scroll[16 +: SCROLL_W];
            color    <= sh_color[23:0];
            if (!commit_wr) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_frame_ctrl.sv
// Self-checking bench for gfx_frame_ctrl: directed table, corner sequences and
// randomized bus/frame traffic against a register-level reference model.
module tb_gfx_frame_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb__adr, wb__dat_w, wb__dat_r;
  logic [3:0]  sel;
  logic        wb__cyc, wb__stb, wb__we, wb__ack;
  logic        frame_start;
  logic        enable;
  logic [1:0]  mode;
  logic [9:0]  scroll_x, scroll_y;
  logic [23:0] color;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  gfx_frame_ctrl #(.BASE_ADDR(BASE), .SCROLL_W(10)) dut (
    .clk(clk), .reset(reset), .wb__adr(wb__adr), .wb__dat_w(wb__dat_w),
    .wb__dat_r(wb__dat_r), .sel(sel), .wb__cyc(wb__cyc), .wb__stb(wb__stb),
    .wb__we(wb__we), .wb__ack(wb__ack), .frame_start(frame_start),
    .enable(enable), .mode(mode), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .color(color), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: register images as seen by software.
  logic [31:0] m_sh [3];
  logic [31:0] m_act[3];
  logic        m_pend, m_irqp;
  logic [15:0] m_cnt;

  function automatic logic [31:0] m_mask(input int i);
    case (i)
      0:       return 32'h0000_0107;
      1:       return 32'h03FF_03FF;
      default: return 32'h00FF_FFFF;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    m_pend = 0; m_irqp = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00, 8'h04, 8'h08: return m_sh[off[3:2]];
      8'h0C:               return {30'h0, m_pend, m_irqp};
      8'h10:               return {16'h0, m_cnt};
      default:             return 32'h0;
    endcase
  endfunction

  task automatic m_step(input logic w, input logic [7:0] off, input logic [31:0] d,
                        input logic [3:0] s, input logic fs);
    logic [31:0] old_sh[3];
    logic        old_pend, commit;
    for (int i = 0; i < 3; i++) old_sh[i] = m_sh[i];
    old_pend = m_pend;
    commit   = 0;
    if (w) begin
      if (off == 8'h00 || off == 8'h04 || off == 8'h08) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) m_sh[off[3:2]][b*8 +: 8] = d[b*8 +: 8];
        m_sh[off[3:2]] &= m_mask(int'(off[3:2]));
      end
      if (off == 8'h0C && s[0] && d[0]) m_irqp = 0;
      if (off == 8'h14) commit = 1;
    end
    if (fs) begin
      if (old_pend) for (int i = 0; i < 3; i++) m_act[i] = old_sh[i];
      m_cnt++;
      m_irqp = 1;
    end
    m_pend = commit ? 1'b1 : (fs ? 1'b0 : old_pend);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".enable"}, {31'h0, enable}, {31'h0, m_act[0][0]});
    chk({tag, ".mode"}, {30'h0, mode}, {30'h0, m_act[0][2:1]});
    chk({tag, ".scroll_x"}, {22'h0, scroll_x}, {22'h0, m_act[1][9:0]});
    chk({tag, ".scroll_y"}, {22'h0, scroll_y}, {22'h0, m_act[1][25:16]});
    chk({tag, ".color"}, {8'h0, color}, {8'h0, m_act[2][23:0]});
    chk({tag, ".irq"}, {31'h0, irq}, {31'h0, m_irqp & m_sh[0][8]});
  endtask

  // One bus transfer starting at posedge+1; optional frame_start on the accept edge.
  task automatic do_xfer(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                         input logic w, input logic fs,
                         output logic [31:0] rd, output logic [31:0] exp);
    exp = w ? 32'h0 : m_read(off);
    wb__adr = BASE | {24'h0, off}; wb__dat_w = d; sel = s; wb__we = w;
    wb__cyc = 1; wb__stb = 1; frame_start = fs;
    @(posedge clk);
    m_step(w, off, d, s, fs);
    #1;
    chk("ack_1cycle", {31'h0, wb__ack}, 32'h1);
    rd = wb__dat_r;
    wb__cyc = 0; wb__stb = 0; wb__we = 0; frame_start = 0;
    @(posedge clk); #1;
    chk("ack_drop", {31'h0, wb__ack}, 32'h0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                    input logic fs);
    logic [31:0] rd, exp;
    do_xfer(off, d, s, 1'b1, fs, rd, exp);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] want);
    logic [31:0] rd, exp;
    do_xfer(off, 32'h0, 4'hF, 1'b0, 1'b0, rd, exp);
    chk(name, rd, want);
  endtask

  task automatic pulse();
    frame_start = 1;
    @(posedge clk);
    m_step(1'b0, 8'h0, 32'h0, 4'h0, 1'b1);
    #1 frame_start = 0;
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp;
    tbl[0]  = '{8'h00, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[1]  = '{8'h04, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[2]  = '{8'h08, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[3]  = '{8'h0C, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[4]  = '{8'h10, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[5]  = '{8'h14, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[6]  = '{8'h18, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[7]  = '{8'h00, 32'h0000_0105, 4'hF, 1'b1, 32'h0};
    tbl[8]  = '{8'h04, 32'h0020_0010, 4'hF, 1'b1, 32'h0};
    tbl[9]  = '{8'h08, 32'h00FF_8000, 4'hF, 1'b1, 32'h0};
    tbl[10] = '{8'h14, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[11] = '{8'h0C, 32'h0,         4'hF, 1'b0, 32'h2};
    tbl[12] = '{8'h00, 32'h0,         4'hF, 1'b0, 32'h0000_0105};
    tbl[13] = '{8'h04, 32'h0,         4'hF, 1'b0, 32'h0020_0010};
    tbl[14] = '{8'h08, 32'h0,         4'hF, 1'b0, 32'h00FF_8000};

    reset = 1; wb__adr = 0; wb__dat_w = 0; sel = 0;
    wb__cyc = 0; wb__stb = 0; wb__we = 0; frame_start = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_ack", {31'h0, wb__ack}, 32'h0);
    chk("rst_dat_r", wb__dat_r, 32'h0);
    chk_outs("rst");

    foreach (tbl[i]) begin
      do_xfer(tbl[i].off, tbl[i].d, tbl[i].s, tbl[i].w, 1'b0, rd, exp);
      if (!tbl[i].w) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
    end
    chk("no_commit_enable", {31'h0, enable}, 32'h0);
    chk("no_commit_color", {8'h0, color}, 32'h0);

    pulse();
    chk("commit_enable", {31'h0, enable}, 32'h1);
    chk("commit_mode", {30'h0, mode}, 32'h2);
    chk("commit_sx", {22'h0, scroll_x}, 32'd16);
    chk("commit_sy", {22'h0, scroll_y}, 32'd32);
    chk("commit_color", {8'h0, color}, 32'h00FF_8000);
    chk("commit_irq", {31'h0, irq}, 32'h1);
    rd_chk("status_after_commit", 8'h0C, 32'h1);

    wr(8'h04, 32'hFFFF_FF05, 4'b0001, 1'b0);
    rd_chk("scroll_bytelane", 8'h04, 32'h0020_0005);

    wr(8'h0C, 32'h1, 4'hF, 1'b0);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    wr(8'h0C, 32'h1, 4'hF, 1'b1);
    chk("w1c_vs_frame_irq", {31'h0, irq}, 32'h1);

    wr(8'h14, 32'h0, 4'hF, 1'b0);
    wr(8'h08, 32'h0012_3456, 4'hF, 1'b0);
    wr(8'h14, 32'h0, 4'h0, 1'b1);
    chk("commit_vs_frame_color", {8'h0, color}, 32'h0012_3456);
    chk("commit_vs_frame_sx", {22'h0, scroll_x}, 32'd5);
    rd_chk("commit_vs_frame_status", 8'h0C, 32'h3);
    wr(8'h08, 32'h00AB_CDEF, 4'hF, 1'b0);
    wr(8'h08, 32'h0011_1111, 4'hF, 1'b1);
    chk("write_vs_transfer_color", {8'h0, color}, 32'h00AB_CDEF);
    rd_chk("write_vs_transfer_status", 8'h0C, 32'h1);
    pulse();
    chk("idle_frame_color", {8'h0, color}, 32'h00AB_CDEF);
    chk_outs("hand");

    // Strobe held over three edges: ack, gap, ack.
    wb__adr = BASE | 32'h10; wb__we = 0; sel = 4'hF; wb__cyc = 1; wb__stb = 1;
    @(posedge clk); #1 chk("held_ack0", {31'h0, wb__ack}, 32'h1);
    @(posedge clk); #1 chk("held_ack1", {31'h0, wb__ack}, 32'h0);
    @(posedge clk); #1 chk("held_ack2", {31'h0, wb__ack}, 32'h1);
    wb__cyc = 0; wb__stb = 0;
    @(posedge clk); #1;

    wb__adr = BASE + 32'h100; wb__cyc = 1; wb__stb = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 chk("miss_ack", {31'h0, wb__ack}, 32'h0);
    end
    wb__cyc = 0; wb__stb = 0;
    @(posedge clk); #1;

    // Reset during the ack cycle, with the master still holding the cycle.
    wb__adr = BASE; wb__cyc = 1; wb__stb = 1;
    @(posedge clk); #1 chk("pre_reset_ack", {31'h0, wb__ack}, 32'h1);
    reset = 1;
    #1 chk("reset_ack_drop", {31'h0, wb__ack}, 32'h0);
    m_reset();
    chk_outs("mid_reset");
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1 chk("post_reset_ack", {31'h0, wb__ack}, 32'h1);
    chk("post_reset_rd", wb__dat_r, 32'h0);
    wb__cyc = 0; wb__stb = 0;
    @(posedge clk); #1;

    frame_start = 1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      m_step(1'b0, 8'h0, 32'h0, 4'h0, 1'b1);
    end
    #1 frame_start = 0;
    rd_chk("cnt_ffff", 8'h10, 32'h0000_FFFF);
    pulse();
    rd_chk("cnt_wrap", 8'h10, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] off;
      logic       w, fs;
      case ($urandom_range(0, 7))
        0: off = 8'h00; 1: off = 8'h04; 2: off = 8'h08; 3: off = 8'h0C;
        4: off = 8'h10; 5: off = 8'h14; 6: off = 8'h18; default: off = 8'hFC;
      endcase
      w  = 1'($urandom_range(0, 1));
      fs = ($urandom_range(0, 3) == 0);
      do_xfer(off, $urandom, 4'($urandom_range(0, 15)), w, fs, rd, exp);
      if (!w) chk($sformatf("rand%0d_rd_%h", i, off), rd, exp);
      if ($urandom_range(0, 7) == 0) pulse();
      chk_outs("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
